// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a signed immediate into a
// 32-bit instruction word, flags range/alignment violations, and queues results in a 2-entry FIFO.
module inst_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic signed [31:0] imm_s;
    logic [31:0]        enc_inst;
    logic               enc_err;

    assign imm_s = in_imm;

    always_comb begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
        case (in_fmt)
            FMT_R: begin
                enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = 1'b0;
            end
            FMT_I: begin
                enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            FMT_S: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            FMT_B: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            end
            FMT_U: begin
                // imm is the upper field itself; it must be a sign-consistent 20-bit value
                enc_inst = {in_imm[19:0], in_rd, in_opcode};
                enc_err  = !((&in_imm[31:19]) || (~|in_imm[31:19]));
            end
            FMT_J: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            end
            default: begin
                enc_inst = NOP_INST;
                enc_err  = 1'b1;
            end
        endcase
    end

    logic [31:0]          slot_inst_q [2];
    logic [31:0]          slot_inst_d [2];
    logic                 slot_err_q  [2];
    logic                 slot_err_d  [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 accept;
    logic                 drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = (count_q != 2'd0) && out_ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_inst_d[i] = slot_inst_q[i];
            slot_err_d[i]  = slot_err_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;

        if (accept) begin
            slot_inst_d[wr_ptr_q] = enc_inst;
            slot_err_d[wr_ptr_q]  = enc_err;
            wr_ptr_d              = ~wr_ptr_q;
            if (enc_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        if (drain)
            rd_ptr_d = ~rd_ptr_q;

        case ({accept, drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Registered ready: a drain at full occupancy only re-opens the input next cycle
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_inst_q[i] <= 32'd0;
                slot_err_q[i]  <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                slot_inst_q[i] <= slot_inst_d[i];
                slot_err_q[i]  <= slot_err_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_inst  = slot_inst_q[rd_ptr_q];
    assign out_err   = slot_err_q[rd_ptr_q];
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder: encodings, range errors, FIFO backpressure,
// full-rate streaming, mid-operation reset and error counter saturation.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = 3'd0;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [15:0] err_cnt;

    logic        s_in_ready, s_out_valid, s_out_err;
    logic [31:0] s_out_inst;
    logic [1:0]  s_err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err_cnt = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    // Narrow-counter instance shares all inputs; used for the saturation path
    inst_encoder #(.ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_inst(s_out_inst),
        .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Present the driven fields for exactly one accepting edge; returns #1 after that edge
    task automatic send_one();
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst got=%h exp=00000000", out_inst); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        $display("reset: out_valid=%0b in_ready=%0b err_cnt=%0d", out_valid, in_ready, err_cnt);
    endtask

    task automatic test_single_i();
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        send_one();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_i_valid got=%0b exp=1", out_valid); end
        checks++; if (out_inst !== 32'hFFF0_0093) begin errors++; $display("FAIL single_i_inst got=%h exp=fff00093", out_inst); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_i_err got=%0b exp=0", out_err); end
        $display("single I: inst=%h err=%0b", out_inst, out_err);
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_i_drained got=%0b exp=0", out_valid); end
    endtask

    task automatic test_encode_bjr();
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_FFF8);
        send_one();
        checks++; if (out_inst !== 32'hFE20_9CE3 || out_err !== 1'b0) begin errors++; $display("FAIL enc_b got=%h/%0b exp=fe209ce3/0", out_inst, out_err); end
        $display("B: inst=%h err=%0b", out_inst, out_err);
        idle();
        drive(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_one();
        checks++; if (out_inst !== 32'h0010_006F || out_err !== 1'b0) begin errors++; $display("FAIL enc_j got=%h/%0b exp=0010006f/0", out_inst, out_err); end
        $display("J: inst=%h err=%0b", out_inst, out_err);
        idle();
        drive(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFF_FFFF);
        send_one();
        checks++; if (out_inst !== 32'h4031_00B3 || out_err !== 1'b0) begin errors++; $display("FAIL enc_r got=%h/%0b exp=403100b3/0", out_inst, out_err); end
        $display("R: inst=%h err=%0b", out_inst, out_err);
        idle();
    endtask

    task automatic test_errors();
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_one();
        exp_err_cnt++;
        checks++; if (out_inst !== 32'h8000_0093 || out_err !== 1'b1) begin errors++; $display("FAIL err_i_range got=%h/%0b exp=80000093/1", out_inst, out_err); end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin errors++; $display("FAIL err_cnt_1 got=%0d exp=%0d", err_cnt, exp_err_cnt); end
        $display("err I: inst=%h err=%0b cnt=%0d", out_inst, out_err, err_cnt);
        idle();
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd3);
        send_one();
        exp_err_cnt++;
        checks++; if (out_inst !== 32'h0020_9163 || out_err !== 1'b1) begin errors++; $display("FAIL err_b_align got=%h/%0b exp=00209163/1", out_inst, out_err); end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin errors++; $display("FAIL err_cnt_2 got=%0d exp=%0d", err_cnt, exp_err_cnt); end
        $display("err B: inst=%h err=%0b cnt=%0d", out_inst, out_err, err_cnt);
        idle();
        drive(3'd7, 7'h33, 5'd5, 5'd6, 5'd7, 3'd2, 7'h20, 32'd0);
        send_one();
        exp_err_cnt++;
        checks++; if (out_inst !== 32'h0000_0013 || out_err !== 1'b1) begin errors++; $display("FAIL err_fmt7 got=%h/%0b exp=00000013/1", out_inst, out_err); end
        checks++; if (err_cnt !== 16'(exp_err_cnt)) begin errors++; $display("FAIL err_cnt_3 got=%0d exp=%0d", err_cnt, exp_err_cnt); end
        $display("err fmt7: inst=%h err=%0b cnt=%0d", out_inst, out_err, err_cnt);
        idle();
    endtask

    task automatic test_boundaries();
        logic [2:0]  t_fmt  [12] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5};
        logic [31:0] t_imm  [12] = '{32'd2047, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'hFFFF_F000, 32'd4096,
                                     32'h0007_FFFF, 32'h0008_0000, 32'hFFFF_FFFF, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
        logic [31:0] t_inst [12] = '{32'h7FF0_0000, 32'h8000_0000, 32'h7E00_0F80, 32'h7E00_0F80, 32'h8000_0000, 32'h8000_0000,
                                     32'h7FFF_F000, 32'h8000_0000, 32'hFFFF_F000, 32'h7FFF_F000, 32'h8000_0000, 32'h8000_0000};
        logic        t_err  [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            drive(t_fmt[i], 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, t_imm[i]);
            send_one();
            if (t_err[i]) exp_err_cnt++;
            checks++;
            if (out_inst !== t_inst[i] || out_err !== t_err[i] || err_cnt !== 16'(exp_err_cnt)) begin
                errors++;
                $display("FAIL bound_%0d got=%h/%0b/%0d exp=%h/%0b/%0d", i, out_inst, out_err, err_cnt,
                         t_inst[i], t_err[i], exp_err_cnt);
            end
            $display("bound %0d: fmt=%0d imm=%h inst=%h err=%0b", i, t_fmt[i], t_imm[i], out_inst, out_err);
            idle();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        idle();
        checks++; if (in_ready !== 1'b1 || out_inst !== 32'h0010_0093) begin errors++; $display("FAIL bp_first got=%0b/%h exp=1/00100093", in_ready, out_inst); end
        drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        idle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        repeat (3) idle();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h0010_0093) begin errors++; $display("FAIL bp_hold got=%0b/%0b/%h exp=0/1/00100093", in_ready, out_valid, out_inst); end
        out_ready = 1'b1;
        idle();
        checks++; if (out_inst !== 32'h0020_0113 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_b got=%h/%0b exp=00200113/1", out_inst, in_ready); end
        idle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0030_0193) begin errors++; $display("FAIL bp_drain_c got=%0b/%h exp=1/00300193", out_valid, out_inst); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
        $display("backpressure: three words drained, out_valid=%0b", out_valid);
    endtask

    task automatic test_stream();
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic [31:0] exp;
        out_ready = 1'b1;
        while (recv < 20 && cyc < 100) begin
            logic will_acc;
            if (sent < 20) begin
                drive(3'd1, 7'h13, 5'(sent), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            will_acc = in_valid && in_ready;
            if (out_valid) begin
                exp = {12'(recv), 5'd0, 3'd0, 5'(recv), 7'h13};
                checks++;
                if (out_inst !== exp) begin errors++; $display("FAIL stream_word_%0d got=%h exp=%h", recv, out_inst, exp); end
                $display("stream out %0d: inst=%h", recv, out_inst);
                recv++;
            end
            cyc++;
            if (recv < 20) begin
                @(posedge clk); #1;
                if (will_acc) sent++;
            end
        end
        in_valid = 1'b0;
        checks++; if (cyc !== 21) begin errors++; $display("FAIL stream_cycles got=%0d exp=21", cyc); end
        idle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send_one();
        drive(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send_one();
        exp_err_cnt++;
        checks++; if (in_ready !== 1'b0 || err_cnt !== 16'(exp_err_cnt)) begin errors++; $display("FAIL mid_full got=%0b/%0d exp=0/%0d", in_ready, err_cnt, exp_err_cnt); end
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        idle();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_err_cnt = 0;
        checks++; if (out_valid !== 1'b0 || out_inst !== 32'd0) begin errors++; $display("FAIL mid_out got=%0b/%h exp=0/00000000", out_valid, out_inst); end
        checks++; if (err_cnt !== 16'd0 || s_err_cnt !== 2'd0) begin errors++; $display("FAIL mid_err_cnt got=%0d/%0d exp=0/0", err_cnt, s_err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
        drive(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_one();
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_006F || out_err !== 1'b0) begin errors++; $display("FAIL mid_after got=%0b/%h/%0b exp=1/0010006f/0", out_valid, out_inst, out_err); end
        $display("mid reset: post-reset word inst=%h", out_inst);
        idle();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        out_ready = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            drive(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
            send_one();
            exp_err_cnt++;
            exp_s = (n > 3) ? 2'd3 : 2'(n);
            checks++;
            if (s_err_cnt !== exp_s || s_out_valid !== 1'b1 || s_out_inst !== 32'h13 || s_out_err !== 1'b1) begin
                errors++;
                $display("FAIL sat_%0d got=%0d/%0b/%h/%0b exp=%0d/1/00000013/1", n, s_err_cnt, s_out_valid, s_out_inst, s_out_err, exp_s);
            end
            checks++;
            if (err_cnt !== 16'(exp_err_cnt)) begin errors++; $display("FAIL sat_wide_%0d got=%0d exp=%0d", n, err_cnt, exp_err_cnt); end
            $display("saturate %0d: narrow cnt=%0d wide cnt=%0d", n, s_err_cnt, err_cnt);
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_encode_bjr();
        test_errors();
        test_boundaries();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
